// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single write port (D / W_ADR / W_en) of a 32x4 tile register file between two
// requesters, A and B. All outputs are registered and drive the register-file BEL directly.
//
// Optional feature: define REGFILE_ARB_CLEAR_EN to enable the clear sweep. When it is enabled,
// every address is written with zero after reset and after each accepted clear_req.
//
// Ports
//   UserCLK     in   clock, rising edge
//   resetn      in   synchronous active-low reset
//   A_req/A_adr/A_data   in   requester A (level request, held until A_gnt)
//   A_gnt       out  one-cycle grant pulse for A; A's write is on W_* in that cycle
//   B_req/B_adr/B_data/B_gnt   as for A
//   clear_req   in   pulse requesting a clear sweep (ignored unless the feature is built in)
//   W_en        out  register-file write enable
//   W_ADR       out  register-file write address
//   D           out  register-file write data
//   busy        out  high while the clear sweep runs
//   ConfigBits  in   [0]: 0 = round-robin, 1 = fixed priority to A

module regfile_write_arbiter #(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 32,
    parameter int NoConfigBits = 1
) (
    input  logic                    UserCLK,
    input  logic                    resetn,
    input  logic                    A_req,
    input  logic [ADDR_W-1:0]       A_adr,
    input  logic [DATA_W-1:0]       A_data,
    output logic                    A_gnt,
    input  logic                    B_req,
    input  logic [ADDR_W-1:0]       B_adr,
    input  logic [DATA_W-1:0]       B_data,
    output logic                    B_gnt,
    input  logic                    clear_req,
    output logic                    W_en,
    output logic [ADDR_W-1:0]       W_ADR,
    output logic [DATA_W-1:0]       D,
    output logic                    busy,
    input  logic [NoConfigBits-1:0] ConfigBits
);

`ifdef REGFILE_ARB_CLEAR_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif

    typedef enum logic {
        S_ARB,
        S_CLEAR
    } state_t;

    // Without the clear feature the FSM never leaves S_ARB.
    localparam state_t RESET_STATE = CLEAR_EN ? S_CLEAR : S_ARB;
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              last_gnt_b;  // 1 when the most recent grant went to B
    logic              a_elig;
    logic              b_elig;
    logic              pick_a;
    logic              pick_b;
    logic              clear_go;

    // A requester whose grant is visible this cycle is masked, so its held req is not
    // mistaken for a second request.
    always_comb begin
        a_elig   = A_req & ~A_gnt;
        b_elig   = B_req & ~B_gnt;
        pick_a   = a_elig & (~b_elig | ConfigBits[0] | last_gnt_b);
        pick_b   = b_elig & ~pick_a;
        clear_go = CLEAR_EN & clear_req;
    end

    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state      <= RESET_STATE;
            ptr        <= '0;
            last_gnt_b <= 1'b1;
            W_en       <= 1'b0;
            W_ADR      <= '0;
            D          <= '0;
            A_gnt      <= 1'b0;
            B_gnt      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            W_en  <= 1'b0;
            A_gnt <= 1'b0;
            B_gnt <= 1'b0;
            busy  <= 1'b0;
            unique case (state)
                S_ARB: begin
                    if (clear_go) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                    end else if (pick_a) begin
                        W_en       <= 1'b1;
                        W_ADR      <= A_adr;
                        D          <= A_data;
                        A_gnt      <= 1'b1;
                        last_gnt_b <= 1'b0;
                    end else if (pick_b) begin
                        W_en       <= 1'b1;
                        W_ADR      <= B_adr;
                        D          <= B_data;
                        B_gnt      <= 1'b1;
                        last_gnt_b <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    W_en  <= 1'b1;
                    W_ADR <= ptr;
                    D     <= '0;
                    busy  <= 1'b1;
                    if (ptr == LAST_ADR) begin
                        state <= S_ARB;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: state <= S_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int DEPTH = 32;
`ifdef REGFILE_ARB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       A_req, B_req, A_gnt, B_gnt;
    logic [4:0] A_adr, B_adr, W_ADR;
    logic [3:0] A_data, B_data, D;
    logic       clear_req, W_en, busy;
    logic [0:0] ConfigBits;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .UserCLK   (clk),
        .resetn    (resetn),
        .A_req     (A_req),
        .A_adr     (A_adr),
        .A_data    (A_data),
        .A_gnt     (A_gnt),
        .B_req     (B_req),
        .B_adr     (B_adr),
        .B_data    (B_data),
        .B_gnt     (B_gnt),
        .clear_req (clear_req),
        .W_en      (W_en),
        .W_ADR     (W_ADR),
        .D         (D),
        .busy      (busy),
        .ConfigBits(ConfigBits)
    );

    typedef struct packed {
        logic       en;
        logic       ga;
        logic       gb;
        logic       busy;
        logic [4:0] adr;
        logic [3:0] data;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         passed = 0;

    // Reference model state: who won last, who holds a grant in the coming cycle.
    int         m_last;        // 0 = A, 1 = B
    int         m_prev;        // -1 none, 0 = A, 1 = B
    int         m_clear_left;
    logic [4:0] m_adr;
    logic [3:0] m_data;
    logic [3:0] m_mem[DEPTH];
    logic [3:0] dmem[DEPTH];   // contents implied by what the DUT actually wrote

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endfunction

    // Predict the outputs that follow the coming rising edge from the inputs now applied.
    function automatic void model_edge();
        exp_t e;
        bit   ea, eb;
        int   win;
        e = '0;
        if (!resetn) begin
            m_last       = 1;
            m_prev       = -1;
            m_adr        = '0;
            m_data       = '0;
            m_clear_left = CLR ? DEPTH : 0;
        end else if (m_clear_left > 0) begin
            e.en   = 1'b1;
            e.busy = 1'b1;
            e.adr  = 5'(DEPTH - m_clear_left);
            e.data = '0;
            m_clear_left--;
            m_prev = -1;
        end else if (CLR && clear_req) begin
            m_clear_left = DEPTH;
            m_prev       = -1;
            e.adr        = m_adr;
            e.data       = m_data;
        end else begin
            ea  = A_req && (m_prev != 0);
            eb  = B_req && (m_prev != 1);
            win = -1;
            if (ea && eb) win = ConfigBits[0] ? 0 : (m_last == 0 ? 1 : 0);
            else if (ea) win = 0;
            else if (eb) win = 1;
            m_prev = win;
            if (win == 0) begin
                e.en = 1'b1; e.ga = 1'b1; e.adr = A_adr; e.data = A_data; m_last = 0;
            end else if (win == 1) begin
                e.en = 1'b1; e.gb = 1'b1; e.adr = B_adr; e.data = B_data; m_last = 1;
            end else begin
                e.adr = m_adr; e.data = m_data;
            end
        end
        if (e.en) m_mem[e.adr] = e.data;
        m_adr  = e.adr;
        m_data = e.data;
        q.push_back(e);
    endfunction

    // Monitor: compare whatever the DUT presents after each edge with the queued prediction.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("w_en", W_en, e.en);
            chk("a_gnt", A_gnt, e.ga);
            chk("b_gnt", B_gnt, e.gb);
            chk("busy", busy, e.busy);
            chk("w_adr", W_ADR, e.adr);
            chk("d", D, e.data);
            if (W_en === 1'b1) dmem[W_ADR] = D;
        end
    end

    task automatic drive_cycle();
        model_edge();
        @(negedge clk);
    endtask

    // Requesters: drop a request once granted, then maybe raise a fresh one (p percent).
    function automatic void agents(int p);
        if (A_req && A_gnt) A_req = 1'b0;
        if (B_req && B_gnt) B_req = 1'b0;
        if (!A_req && $urandom_range(99) < p) begin
            A_req = 1'b1; A_adr = 5'($urandom); A_data = 4'($urandom);
        end
        if (!B_req && $urandom_range(99) < p) begin
            B_req = 1'b1; B_adr = 5'($urandom); B_data = 4'($urandom);
        end
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        drive_cycle();
        resetn = 1'b1;
        if (CLR) repeat (DEPTH) drive_cycle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            dmem[i]  = '0;
        end
        resetn = 1'b0; A_req = 1'b0; B_req = 1'b0; clear_req = 1'b0; ConfigBits = 1'b0;
        A_adr = '0; B_adr = '0; A_data = '0; B_data = '0;
        @(negedge clk);

        // Single requester A.
        do_reset();
        A_req = 1'b1; A_adr = 5'h03; A_data = 4'hA;
        drive_cycle();
        chk("t1_a_gnt", A_gnt, 1'b1);
        chk("t1_w_adr", W_ADR, 5'h03);
        chk("t1_d", D, 4'hA);
        A_req = 1'b0;
        drive_cycle();

        // Same-address collision: later grant (B) must persist.
        do_reset();
        A_req = 1'b1; A_adr = 5'd7; A_data = 4'h1;
        B_req = 1'b1; B_adr = 5'd7; B_data = 4'h2;
        for (int i = 0; i < 4; i++) begin
            drive_cycle();
            if (A_gnt) A_req = 1'b0;
            if (B_gnt) B_req = 1'b0;
        end
        drive_cycle();
        chk("t4_mem7", dmem[7], 4'h2);

        // Continuous requests from both sides, round-robin then fixed priority.
        for (int c = 0; c < 2; c++) begin
            ConfigBits = 1'(c);
            do_reset();
            for (int i = 0; i < 12; i++) begin
                agents(100);
                drive_cycle();
            end
        end

        // Randomized traffic with resets, clear pulses and mode changes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ConfigBits = 1'($urandom);
            agents(60);
            clear_req = ($urandom_range(49) == 0);
            resetn    = ($urandom_range(149) != 0);
            drive_cycle();
        end
        resetn = 1'b1; clear_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            agents(0);
            drive_cycle();
        end

        @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        for (int i = 0; i < DEPTH; i++) chk("mem_contents", dmem[i], m_mem[i]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
